// File: rtl/demux_1_2_stream.sv
// -----------------------------------------------------------------------------
// demux_1_2_stream
//   Steers one valid/ready input stream to one of two output channels
//   (A when in_sel_i=0, B when in_sel_i=1). Each channel has its own FIFO, so
//   back-pressure on one channel blocks only the beats addressed to it.
//   Each channel also has a free-running beat counter of delivered (popped)
//   beats for link debug.
//
// Parameters
//   WIDTH  data width of the input and both outputs
//   DEPTH  entries per channel FIFO (power of two, >= 2)
//   CNT_W  width of each channel beat counter
//
// Ports
//   clk_i       single clock, rising edge
//   rst_i       asynchronous, active-high reset
//   in_data_i   input beat data
//   in_sel_i    destination: 0 = A, 1 = B
//   in_valid_i  input beat valid
//   in_ready_o  beat is accepted this cycle (combinational on selected FIFO)
//   a_data_o    channel A head data
//   a_valid_o   channel A FIFO non-empty
//   a_ready_i   channel A consumer ready
//   b_data_o    channel B head data
//   b_valid_o   channel B FIFO non-empty
//   b_ready_i   channel B consumer ready
//   a_count_o   beats delivered on A (wraps)
//   b_count_o   beats delivered on B (wraps)
// -----------------------------------------------------------------------------
module demux_1_2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_sel_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] a_data_o,
  output logic             a_valid_o,
  input  logic             a_ready_i,
  output logic [WIDTH-1:0] b_data_o,
  output logic             b_valid_o,
  input  logic             b_ready_i,
  output logic [CNT_W-1:0] a_count_o,
  output logic [CNT_W-1:0] b_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Channel A storage and pointers (one extra MSB to tell full from empty)
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [AW:0]      wr_a_q, wr_a_d;
  logic [AW:0]      rd_a_q, rd_a_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;

  // Channel B storage and pointers
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [AW:0]      wr_b_q, wr_b_d;
  logic [AW:0]      rd_b_q, rd_b_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic full_a, empty_a, push_a, pop_a;
  logic full_b, empty_b, push_b, pop_b;

  // ---------------------------------------------------------------------------
  // Status flags, derived only from registered pointers
  // ---------------------------------------------------------------------------
  always_comb begin
    full_a  = (wr_a_q[AW] != rd_a_q[AW]) && (wr_a_q[AW-1:0] == rd_a_q[AW-1:0]);
    empty_a = (wr_a_q == rd_a_q);
    full_b  = (wr_b_q[AW] != rd_b_q[AW]) && (wr_b_q[AW-1:0] == rd_b_q[AW-1:0]);
    empty_b = (wr_b_q == rd_b_q);
  end

  // ---------------------------------------------------------------------------
  // Handshakes. A pop this cycle does not free space for a push in the same
  // cycle: in_ready_o sees only the registered full flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_o = in_sel_i ? !full_b : !full_a;
    a_valid_o  = !empty_a;
    b_valid_o  = !empty_b;
    push_a     = in_valid_i && in_ready_o && !in_sel_i;
    push_b     = in_valid_i && in_ready_o &&  in_sel_i;
    pop_a      = a_valid_o && a_ready_i;
    pop_b      = b_valid_o && b_ready_i;
  end

  // Head of each FIFO; stale contents when empty
  always_comb begin
    a_data_o  = mem_a_q[rd_a_q[AW-1:0]];
    b_data_o  = mem_b_q[rd_b_q[AW-1:0]];
    a_count_o = cnt_a_q;
    b_count_o = cnt_b_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state for pointers and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_a_d  = wr_a_q;
    rd_a_d  = rd_a_q;
    cnt_a_d = cnt_a_q;
    if (push_a) wr_a_d = wr_a_q + PTR_ONE;
    if (pop_a) begin
      rd_a_d  = rd_a_q + PTR_ONE;
      cnt_a_d = cnt_a_q + CNT_ONE;
    end
  end

  always_comb begin
    wr_b_d  = wr_b_q;
    rd_b_d  = rd_b_q;
    cnt_b_d = cnt_b_q;
    if (push_b) wr_b_d = wr_b_q + PTR_ONE;
    if (pop_b) begin
      rd_b_d  = rd_b_q + PTR_ONE;
      cnt_b_d = cnt_b_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_a_q  <= '0;
      rd_a_q  <= '0;
      cnt_a_q <= '0;
      wr_b_q  <= '0;
      rd_b_q  <= '0;
      cnt_b_q <= '0;
    end else begin
      wr_a_q  <= wr_a_d;
      rd_a_q  <= rd_a_d;
      cnt_a_q <= cnt_a_d;
      wr_b_q  <= wr_b_d;
      rd_b_q  <= rd_b_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  // Storage is cleared on reset so the head data reads 0 out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
    end else begin
      if (push_a) mem_a_q[wr_a_q[AW-1:0]] <= in_data_i;
      if (push_b) mem_b_q[wr_b_q[AW-1:0]] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_demux_1_2_stream.sv
module tb_demux_1_2_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  int checks = 0;
  int errors = 0;

  demux_1_2_stream #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .in_data_i (in_data),
    .in_sel_i  (in_sel),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .a_data_o  (a_data),
    .a_valid_o (a_valid),
    .a_ready_i (a_ready),
    .b_data_o  (b_data),
    .b_valid_o (b_valid),
    .b_ready_i (b_ready),
    .a_count_o (a_count),
    .b_count_o (b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (inputs change here, one posedge later)
  task automatic next();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [CNT_W-1:0] ea, eb;
  logic             exp_rdy;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    a_ready = 1'b0;
    b_ready = 1'b0;
    next(); next();
    #1;
    // ---------------- reset state
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_b_count", b_count, 0);
    chk("rst_in_ready", in_ready, 1);
    next();
    rst = 1'b0;

    // ---------------- routing, both readies high
    a_ready = 1'b1; b_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h11); #1;
    chk("rt0_in_ready", in_ready, 1);
    chk("rt0_a_valid", a_valid, 0);
    next(); drive(1'b1, 1'b1, 8'h22); #1;
    chk("rt1_a_valid", a_valid, 1);
    chk("rt1_a_data", a_data, 8'h11);
    chk("rt1_b_valid", b_valid, 0);
    next(); drive(1'b1, 1'b0, 8'h33); #1;
    chk("rt2_b_valid", b_valid, 1);
    chk("rt2_b_data", b_data, 8'h22);
    chk("rt2_a_valid", a_valid, 0);
    next(); drive(1'b0, 1'b0, 8'h00); #1;
    chk("rt3_a_valid", a_valid, 1);
    chk("rt3_a_data", a_data, 8'h33);
    chk("rt3_b_valid", b_valid, 0);
    next(); #1;
    chk("rt4_a_valid", a_valid, 0);
    chk("rt4_a_count", a_count, 2);
    chk("rt4_b_count", b_count, 1);

    // ---------------- back-pressure isolation
    a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b1, 1'b0, 8'hA1); #1;
    chk("bp0_in_ready", in_ready, 1);
    next(); drive(1'b1, 1'b0, 8'hA2); #1;
    chk("bp1_in_ready", in_ready, 1);
    next(); drive(1'b1, 1'b0, 8'hA3); #1;
    chk("bp2_in_ready_full", in_ready, 0);
    chk("bp2_a_data", a_data, 8'hA1);
    next(); drive(1'b1, 1'b1, 8'h5A); #1;
    chk("bp3_in_ready_b", in_ready, 1);
    chk("bp3_b_valid", b_valid, 0);
    next(); drive(1'b0, 1'b0, 8'h00); #1;
    chk("bp4_b_valid", b_valid, 1);
    chk("bp4_b_data", b_data, 8'h5A);
    chk("bp4_a_data", a_data, 8'hA1);
    chk("bp4_a_count", a_count, 2);

    // ---------------- full plus pop: no same-cycle pop-through
    next(); drive(1'b1, 1'b0, 8'hA3); a_ready = 1'b1; #1;
    chk("fp0_in_ready", in_ready, 0);
    next(); #1;
    chk("fp1_in_ready", in_ready, 1);
    chk("fp1_a_data", a_data, 8'hA2);
    next(); drive(1'b0, 1'b0, 8'h00); b_ready = 1'b1; #1;
    chk("fp2_a_valid", a_valid, 1);
    chk("fp2_a_data", a_data, 8'hA3);
    next(); #1;
    chk("fp3_a_valid", a_valid, 0);
    chk("fp3_b_valid", b_valid, 0);
    chk("fp3_a_count", a_count, 5);
    chk("fp3_b_count", b_count, 2);

    // ---------------- reset mid-stream with A holding 2 beats
    a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b1, 1'b0, 8'hC1);
    next(); drive(1'b1, 1'b0, 8'hC2);
    next(); drive(1'b0, 1'b0, 8'h00); #1;
    chk("mr_pre_full", in_ready, 0);
    rst = 1'b1; #1;
    chk("mr_a_valid", a_valid, 0);
    chk("mr_a_count", a_count, 0);
    chk("mr_b_count", b_count, 0);
    chk("mr_in_ready", in_ready, 1);
    next(); rst = 1'b0;

    // ---------------- wrap: 17 beats through B, counter wraps to 1
    b_ready = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      drive(i < 17, 1'b1, 8'(8'h80 + i)); #1;
      if (i > 0) begin
        chk("wr_b_valid", b_valid, 1);
        chk("wr_b_data", b_data, 8'h80 + i - 1);
      end
      next();
    end
    #1;
    chk("wr_b_valid_end", b_valid, 0);
    chk("wr_b_count", b_count, 1);
    chk("wr_a_count", a_count, 0);

    // ---------------- random traffic against a scoreboard
    ea = 4'd0;
    eb = 4'd1;
    drive(1'b0, 1'b0, '0);
    for (int c = 0; c < 10000; c++) begin
      // hold the beat while it is stalled, else pick a fresh one
      if (!(in_valid && !in_ready))
        drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom));
      a_ready = ($urandom_range(0, 2) != 0);
      b_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
      chk("rnd_in_ready", in_ready, exp_rdy);
      chk("rnd_a_valid", a_valid, qa.size() != 0);
      chk("rnd_b_valid", b_valid, qb.size() != 0);
      if (qa.size() != 0 && a_ready) begin
        chk("rnd_a_data", a_data, qa.pop_front());
        ea = ea + 1'b1;
      end
      if (qb.size() != 0 && b_ready) begin
        chk("rnd_b_data", b_data, qb.pop_front());
        eb = eb + 1'b1;
      end
      if (in_valid && exp_rdy) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
      next();
    end
    drive(1'b0, 1'b0, '0);
    a_ready = 1'b0; b_ready = 1'b0;
    #1;
    chk("rnd_a_count", a_count, ea);
    chk("rnd_b_count", b_count, eb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
